mem_issue_queue: RTL and testbench
==================================

// Module: mem_issue_queue
// PURPOSE
//  In-order issue queue + address generation for loads/stores, directly upstream of the load/store buffer.
//  Accepts mem ops from dispatch; snoops the CDB for base (rs1) and store-data (rs2) operands.
//  When the head entry has all operands, computes addr = rs1 + imm, byte mask and aligned store data, and hands it downstream.
//  In-order issue preserves program memory order for the buffer.
// PARAMETERS
//  DEPTH      8   queue entries, power of two
//  PTAG_W     6   physical register tag width
//  ROB_IDX_W  5   ROB index width
// PORTS
//  clk            in   1          clock
//  rst            in   1          asynchronous reset, active high
//  flush          in   1          sync pipeline flush (branch mispredict)
//  disp_valid     in   1          dispatch offers an op
//  disp_ready     out  1          queue can accept (= !full)
//  disp_is_store  in   1          1 = store, 0 = load
//  disp_funct3    in   3          RV32I width/sign code
//  disp_imm       in   32         sign-extended offset
//  disp_rob_idx   in   ROB_IDX_W  ROB entry of the op
//  disp_ps1       in   PTAG_W     base tag;  disp_ps1_rdy / disp_ps1_v (1 / 32): ready flag, value
//  disp_ps2       in   PTAG_W     store-data tag; disp_ps2_rdy / disp_ps2_v (1 / 32); ignored for loads
//  cdb_valid      in   1          CDB broadcast valid
//  cdb_ptag       in   PTAG_W     broadcast tag
//  cdb_data       in   32         broadcast value
//  out_valid      out  1          head op issuing
//  out_ready      in   1          load/store buffer accepts
//  out_is_store   out  1
//  out_addr       out  32         full byte address rs1+imm
//  out_mask       out  4          byte-lane mask
//  out_wdata      out  32         lane-aligned store data (0 for loads)
//  out_funct3     out  3
//  out_rob_idx    out  ROB_IDX_W
//  out_misaligned out  1          half with addr[0]=1 or word with addr[1:0]!=0
// BEHAVIOUR
//  - Circular FIFO, head/tail pointers of clog2(DEPTH)+1 bits; full = MSBs differ, low bits equal; empty = equal.
//  - Reset (async): pointers 0, all entry valid bits 0; outputs: out_valid 0, disp_ready 1, data outputs 0.
//  - Dispatch: write at tail on disp_valid && disp_ready. disp_ready = !full; no pass-through when full even if head pops same cycle.
//  - Same-cycle CDB bypass at dispatch: if cdb_valid && cdb_ptag == disp_psN and !disp_psN_rdy, entry stores cdb_data, rdy=1.
//  - Snoop: each cycle, every valid entry with rdy=0 and tag == cdb_ptag captures cdb_data, sets rdy. Tag 0 never broadcast; dispatch marks it ready.
//  - Issue: out_valid = head valid && ps1_rdy && (load || ps2_rdy); outputs combinational from head entry.
//    Pop on out_valid && out_ready. Younger ready entries never bypass a stalled head.
//  - Latency: op dispatched with ready operands in cycle N -> out_valid in N+1. Operand arriving on CDB in N -> out_valid N+1.
//  - AGU: addr = rs1_v + imm, mod 2^32 (wrap ignored). off = addr[1:0].
//    mask: B/BU 4'b0001<<off; H/HU 4'b0011<<off; W 4'b1111. out_wdata = rs2_v << (8*off) for stores.
//    Misaligned ops still issue with out_misaligned=1, mask truncated to 4 bits; downstream raises the trap.
//  - Simultaneous dispatch + pop: both take effect; count unchanged.
//  - flush: next edge clears all valids and pointers; flush beats dispatch and pop; out_valid 0 the cycle after.
//  - Reset mid-operation: queue empties immediately; in-flight handshake is dropped.
// STRUCTURE
//  - Package (params): mem_iq_entry_t struct {valid, is_store, funct3, imm, rob_idx, ps1, ps1_rdy, ps1_v, ps2, ps2_rdy, ps2_v}; DEPTH/PTAG_W/ROB_IDX_W constants; funct3 encodings.
//  - One sub-module: mem_agu (combinational: rs1_v, imm, funct3, rs2_v -> addr, mask, wdata, misaligned).
//  - Queue storage, pointers and CDB snoop in this module.
// TESTING
//  1. LW, ps1 ready v=0x1000, imm=0x8 -> next cycle out_valid, addr 0x1008, mask 4'b1111, misaligned 0.
//  2. SB, ps1 v=0x2001, imm=2, ps2 tag 7 not ready; CDB tag 7 data 0xAB in cycle 3 -> issue cycle 4, addr 0x2003, mask 4'b1000, wdata 0xAB000000.
//  3. Fill 8 ops with head stalled -> disp_ready 0; out_ready=1 with ready head -> pop, disp_ready 1 next cycle; 20 ops total check wrap and order of rob_idx.
//  4. Head waits on tag 5, younger entry ready -> out_valid 0 until tag 5 broadcast; then issue in order.
//  5. LH at addr 0x3001 -> out_misaligned 1, mask 4'b0110; LHU at 0x3002 -> mask 4'b1100, misaligned 0.
//  6. Queue holds 4 ops, flush asserted with disp_valid -> next cycle empty, out_valid 0; assert rst mid-fill -> immediate empty.

Source files
------------

// File: rtl/mem_issue_queue_pkg.sv
// Shared types and constants for the in-order memory issue queue.
// Holds the queue entry layout and the RV32I load/store width codes.
package mem_issue_queue_pkg;

   localparam int unsigned DEPTH     = 8;
   localparam int unsigned PTAG_W    = 6;
   localparam int unsigned ROB_IDX_W = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic                 valid;
      logic                 is_store;
      logic [2:0]           funct3;
      logic [31:0]          imm;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PTAG_W-1:0]    ps1;
      logic                 ps1_rdy;
      logic [31:0]          ps1_v;
      logic [PTAG_W-1:0]    ps2;
      logic                 ps2_rdy;
      logic [31:0]          ps2_v;
   } mem_iq_entry_t;

endpackage

// File: rtl/mem_issue_queue_agu.sv
// Combinational address generation: effective address, byte-lane mask,
// lane-aligned store data and misalignment flag.
module mem_issue_queue_agu
   import mem_issue_queue_pkg::*;
(
   input  logic [31:0] rs1_v,
   input  logic [31:0] imm,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs2_v,
   output logic [31:0] addr,
   output logic [3:0]  mask,
   output logic [31:0] wdata,
   output logic        misaligned
);

   logic [1:0] off;

   always_comb begin
      addr       = rs1_v + imm;
      off        = addr[1:0];
      mask       = 4'b0000;
      misaligned = 1'b0;
      case (funct3)
         F3_B, F3_BU: mask = 4'b0001 << off;
         // A misaligned half at offset 3 keeps only the in-word lane.
         F3_H, F3_HU: begin
            mask       = 4'b0011 << off;
            misaligned = addr[0];
         end
         F3_W: begin
            mask       = 4'b1111;
            misaligned = |addr[1:0];
         end
         default: mask = 4'b0000;
      endcase
      wdata = rs2_v << {off, 3'b000};
   end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue with CDB operand snooping; the head entry
// issues through the AGU once its operands are ready.
module mem_issue_queue #(
   parameter int unsigned DEPTH     = mem_issue_queue_pkg::DEPTH,
   parameter int unsigned PTAG_W    = mem_issue_queue_pkg::PTAG_W,
   parameter int unsigned ROB_IDX_W = mem_issue_queue_pkg::ROB_IDX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 disp_valid,
   output logic                 disp_ready,
   input  logic                 disp_is_store,
   input  logic [2:0]           disp_funct3,
   input  logic [31:0]          disp_imm,
   input  logic [ROB_IDX_W-1:0] disp_rob_idx,
   input  logic [PTAG_W-1:0]    disp_ps1,
   input  logic                 disp_ps1_rdy,
   input  logic [31:0]          disp_ps1_v,
   input  logic [PTAG_W-1:0]    disp_ps2,
   input  logic                 disp_ps2_rdy,
   input  logic [31:0]          disp_ps2_v,
   input  logic                 cdb_valid,
   input  logic [PTAG_W-1:0]    cdb_ptag,
   input  logic [31:0]          cdb_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_is_store,
   output logic [31:0]          out_addr,
   output logic [3:0]           out_mask,
   output logic [31:0]          out_wdata,
   output logic [2:0]           out_funct3,
   output logic [ROB_IDX_W-1:0] out_rob_idx,
   output logic                 out_misaligned
);
   import mem_issue_queue_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);

   mem_iq_entry_t q_q [DEPTH];
   mem_iq_entry_t q_d [DEPTH];
   mem_iq_entry_t head_e, new_e;
   logic [AW:0]   head_q, tail_q;
   logic          full, push, pop;
   logic [31:0]   agu_addr, agu_wdata;
   logic [3:0]    agu_mask;
   logic          agu_mis;

   assign full       = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
   assign disp_ready = !full;
   assign push       = disp_valid && !full;
   assign head_e     = q_q[head_q[AW-1:0]];
   assign out_valid  = head_e.valid && head_e.ps1_rdy && (!head_e.is_store || head_e.ps2_rdy);
   assign pop        = out_valid && out_ready;

   // Operands not yet ready may be caught from the CDB in the dispatch cycle;
   // tag 0 is the hardwired zero register and never broadcast.
   always_comb begin
      new_e          = '0;
      new_e.valid    = 1'b1;
      new_e.is_store = disp_is_store;
      new_e.funct3   = disp_funct3;
      new_e.imm      = disp_imm;
      new_e.rob_idx  = disp_rob_idx;
      new_e.ps1      = disp_ps1;
      new_e.ps1_rdy  = 1'b1;
      new_e.ps1_v    = disp_ps1_v;
      new_e.ps2      = disp_ps2;
      new_e.ps2_rdy  = 1'b1;
      new_e.ps2_v    = disp_ps2_v;
      if (!disp_ps1_rdy) begin
         if (cdb_valid && cdb_ptag == disp_ps1) new_e.ps1_v = cdb_data;
         else if (disp_ps1 == '0)              new_e.ps1_v = '0;
         else                                  new_e.ps1_rdy = 1'b0;
      end
      if (!disp_ps2_rdy) begin
         if (cdb_valid && cdb_ptag == disp_ps2) new_e.ps2_v = cdb_data;
         else if (disp_ps2 == '0)              new_e.ps2_v = '0;
         else                                  new_e.ps2_rdy = 1'b0;
      end
   end

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         q_d[i] = q_q[i];
         if (q_q[i].valid && cdb_valid) begin
            if (!q_q[i].ps1_rdy && q_q[i].ps1 == cdb_ptag) begin
               q_d[i].ps1_rdy = 1'b1;
               q_d[i].ps1_v   = cdb_data;
            end
            if (!q_q[i].ps2_rdy && q_q[i].ps2 == cdb_ptag) begin
               q_d[i].ps2_rdy = 1'b1;
               q_d[i].ps2_v   = cdb_data;
            end
         end
      end
      if (pop)  q_d[head_q[AW-1:0]].valid = 1'b0;
      if (push) q_d[tail_q[AW-1:0]] = new_e;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) q_q[i] <= '0;
      end else if (flush) begin
         head_q <= '0;
         tail_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) q_q[i].valid <= 1'b0;
      end else begin
         head_q <= head_q + (AW+1)'(pop);
         tail_q <= tail_q + (AW+1)'(push);
         for (int i = 0; i < int'(DEPTH); i++) q_q[i] <= q_d[i];
      end
   end

   mem_issue_queue_agu u_agu (
      .rs1_v      (head_e.ps1_v),
      .imm        (head_e.imm),
      .funct3     (head_e.funct3),
      .rs2_v      (head_e.ps2_v),
      .addr       (agu_addr),
      .mask       (agu_mask),
      .wdata      (agu_wdata),
      .misaligned (agu_mis)
   );

   // Data outputs read as zero whenever nothing is issuing.
   assign out_is_store   = out_valid && head_e.is_store;
   assign out_addr       = out_valid ? agu_addr : '0;
   assign out_mask       = out_valid ? agu_mask : '0;
   assign out_wdata      = (out_valid && head_e.is_store) ? agu_wdata : '0;
   assign out_funct3     = out_valid ? head_e.funct3 : '0;
   assign out_rob_idx    = out_valid ? head_e.rob_idx : '0;
   assign out_misaligned = out_valid && agu_mis;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed self-checking bench for mem_issue_queue: latency, CDB wakeup,
// full/wrap ordering, head blocking, AGU masks, flush and async reset.
module tb_mem_issue_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        disp_valid = 1'b0, disp_ready, disp_is_store = 1'b0;
   logic [2:0]  disp_funct3 = '0;
   logic [31:0] disp_imm = '0;
   logic [4:0]  disp_rob_idx = '0;
   logic [5:0]  disp_ps1 = '0, disp_ps2 = '0;
   logic        disp_ps1_rdy = 1'b0, disp_ps2_rdy = 1'b0;
   logic [31:0] disp_ps1_v = '0, disp_ps2_v = '0;
   logic        cdb_valid = 1'b0;
   logic [5:0]  cdb_ptag = '0;
   logic [31:0] cdb_data = '0;
   logic        out_valid, out_ready = 1'b0, out_is_store, out_misaligned;
   logic [31:0] out_addr, out_wdata;
   logic [3:0]  out_mask;
   logic [2:0]  out_funct3;
   logic [4:0]  out_rob_idx;

   int checks = 0;
   int failures = 0;

   mem_issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_store(disp_is_store),
      .disp_funct3(disp_funct3), .disp_imm(disp_imm), .disp_rob_idx(disp_rob_idx),
      .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy), .disp_ps1_v(disp_ps1_v),
      .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy), .disp_ps2_v(disp_ps2_v),
      .cdb_valid(cdb_valid), .cdb_ptag(cdb_ptag), .cdb_data(cdb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_is_store(out_is_store),
      .out_addr(out_addr), .out_mask(out_mask), .out_wdata(out_wdata),
      .out_funct3(out_funct3), .out_rob_idx(out_rob_idx), .out_misaligned(out_misaligned)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                           input logic [4:0] rob, input logic [5:0] p1, input logic r1,
                           input logic [31:0] v1, input logic [5:0] p2, input logic r2,
                           input logic [31:0] v2);
      disp_valid = 1'b1; disp_is_store = st; disp_funct3 = f3; disp_imm = imm;
      disp_rob_idx = rob; disp_ps1 = p1; disp_ps1_rdy = r1; disp_ps1_v = v1;
      disp_ps2 = p2; disp_ps2_rdy = r2; disp_ps2_v = v2;
   endtask

   task automatic idle();
      disp_valid = 1'b0; cdb_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #2;
      checks++; if (out_valid !== 1'b0) begin failures++;
         $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
      checks++; if (disp_ready !== 1'b1) begin failures++;
         $display("FAIL reset_disp_ready got=%0h exp=1", disp_ready); end
      checks++; if (out_addr !== 32'h0 || out_mask !== 4'h0 || out_wdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", out_addr, out_mask, out_wdata); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_lw();
      drive_op(1'b0, 3'b010, 32'h8, 5'd1, 6'd3, 1'b1, 32'h1000, 6'd0, 1'b1, 32'h0);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++;
         $display("FAIL lw_not_yet got=%0h exp=0", out_valid); end
      step();
      idle();
      checks++; if (out_valid !== 1'b1 || out_rob_idx !== 5'd1) begin failures++;
         $display("FAIL lw_issue got=%0h/%0d exp=1/1", out_valid, out_rob_idx); end
      checks++; if (out_addr !== 32'h1008 || out_mask !== 4'b1111 || out_misaligned !== 1'b0)
         begin failures++;
         $display("FAIL lw_agu got=%h/%b/%0h exp=1008/1111/0", out_addr, out_mask,
                  out_misaligned); end
      checks++; if (out_is_store !== 1'b0 || out_wdata !== 32'h0) begin failures++;
         $display("FAIL lw_wdata got=%0h/%h exp=0/0", out_is_store, out_wdata); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++;
         $display("FAIL lw_popped got=%0h exp=0", out_valid); end
   endtask

   task automatic test_sb_wakeup();
      drive_op(1'b1, 3'b000, 32'h2, 5'd2, 6'd4, 1'b1, 32'h2001, 6'd7, 1'b0, 32'h0);
      step();
      idle();
      checks++; if (out_valid !== 1'b0) begin failures++;
         $display("FAIL sb_wait1 got=%0h exp=0", out_valid); end
      step();
      cdb_valid = 1'b1; cdb_ptag = 6'd7; cdb_data = 32'hAB;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++;
         $display("FAIL sb_wait2 got=%0h exp=0", out_valid); end
      step();
      cdb_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_is_store !== 1'b1) begin failures++;
         $display("FAIL sb_issue got=%0h/%0h exp=1/1", out_valid, out_is_store); end
      checks++; if (out_addr !== 32'h2003 || out_mask !== 4'b1000 || out_wdata !== 32'hAB000000)
         begin failures++;
         $display("FAIL sb_agu got=%h/%b/%h exp=2003/1000/ab000000", out_addr, out_mask,
                  out_wdata); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_bypass();
      drive_op(1'b1, 3'b010, 32'h0, 5'd6, 6'd2, 1'b1, 32'h100, 6'd8, 1'b0, 32'h0);
      cdb_valid = 1'b1; cdb_ptag = 6'd8; cdb_data = 32'hDEADBEEF;
      step();
      idle();
      checks++; if (out_valid !== 1'b1 || out_wdata !== 32'hDEADBEEF || out_mask !== 4'hF) begin
         failures++;
         $display("FAIL bypass got=%0h/%h/%b exp=1/deadbeef/1111", out_valid, out_wdata,
                  out_mask); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   // Op k: load, rob k, addr k*16; op 0 waits on tag 9 whose value is 0.
   task automatic drive_k(input int k);
      if (k == 0) drive_op(1'b0, 3'b010, 32'h0, 5'd0, 6'd9, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      else drive_op(1'b0, 3'b010, 32'h0, 5'(k), 6'd1, 1'b1, 32'(k) << 4, 6'd0, 1'b1, 32'h0);
   endtask

   task automatic test_full_wrap();
      int next_disp;
      int exp_pop;
      int cyc;
      logic accepted;
      for (int k = 0; k < 8; k++) begin
         drive_k(k);
         step();
      end
      drive_k(8);
      #1;
      checks++; if (disp_ready !== 1'b0 || out_valid !== 1'b0) begin failures++;
         $display("FAIL full_stalled got=%0h/%0h exp=0/0", disp_ready, out_valid); end
      cdb_valid = 1'b1; cdb_ptag = 6'd9; cdb_data = 32'h0;
      step();
      cdb_valid = 1'b0;
      checks++; if (disp_ready !== 1'b0 || out_valid !== 1'b1) begin failures++;
         $display("FAIL full_head_ready got=%0h/%0h exp=0/1", disp_ready, out_valid); end
      next_disp = 8;
      exp_pop = 0;
      cyc = 0;
      while (exp_pop < 20 && cyc < 100) begin
         if (next_disp < 20) drive_k(next_disp);
         else disp_valid = 1'b0;
         out_ready = 1'b1;
         #1;
         if (cyc == 1) begin
            checks++; if (disp_ready !== 1'b1) begin failures++;
               $display("FAIL ready_after_pop got=%0h exp=1", disp_ready); end
         end
         accepted = disp_valid && disp_ready;
         if (out_valid) begin
            checks++;
            if (out_rob_idx !== 5'(exp_pop) || out_addr !== (32'(exp_pop) << 4)) begin
               failures++;
               $display("FAIL wrap_order got=%0d/%h exp=%0d/%h", out_rob_idx, out_addr,
                        exp_pop, 32'(exp_pop) << 4);
            end
            exp_pop++;
         end
         step();
         if (accepted) next_disp++;
         cyc++;
      end
      idle();
      checks++; if (exp_pop != 20) begin failures++;
         $display("FAIL wrap_count got=%0d exp=20", exp_pop); end
      checks++; if (out_valid !== 1'b0 || disp_ready !== 1'b1) begin failures++;
         $display("FAIL wrap_empty got=%0h/%0h exp=0/1", out_valid, disp_ready); end
   endtask

   task automatic test_head_block();
      drive_op(1'b0, 3'b010, 32'h4, 5'd10, 6'd5, 1'b0, 32'h0, 6'd0, 1'b1, 32'h0);
      step();
      drive_op(1'b0, 3'b010, 32'h0, 5'd11, 6'd1, 1'b1, 32'h600, 6'd0, 1'b1, 32'h0);
      step();
      idle();
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (out_valid !== 1'b0) begin failures++;
            $display("FAIL head_blocked cyc=%0d got=%0h exp=0", i, out_valid); end
         step();
      end
      out_ready = 1'b0;
      cdb_valid = 1'b1; cdb_ptag = 6'd5; cdb_data = 32'h500;
      step();
      cdb_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_rob_idx !== 5'd10 || out_addr !== 32'h504) begin
         failures++;
         $display("FAIL head_first got=%0h/%0d/%h exp=1/10/504", out_valid, out_rob_idx,
                  out_addr); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b1 || out_rob_idx !== 5'd11 || out_addr !== 32'h600) begin
         failures++;
         $display("FAIL head_second got=%0h/%0d/%h exp=1/11/600", out_valid, out_rob_idx,
                  out_addr); end
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++;
         $display("FAIL head_drained got=%0h exp=0", out_valid); end
   endtask

   task automatic test_misaligned();
      drive_op(1'b0, 3'b001, 32'h1, 5'd12, 6'd1, 1'b1, 32'h3000, 6'd0, 1'b1, 32'h0);
      step();
      drive_op(1'b0, 3'b101, 32'h2, 5'd13, 6'd1, 1'b1, 32'h3000, 6'd0, 1'b1, 32'h0);
      step();
      idle();
      checks++; if (out_addr !== 32'h3001 || out_mask !== 4'b0110 || out_misaligned !== 1'b1)
         begin failures++;
         $display("FAIL lh_mis got=%h/%b/%0h exp=3001/0110/1", out_addr, out_mask,
                  out_misaligned); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++; if (out_addr !== 32'h3002 || out_mask !== 4'b1100 || out_misaligned !== 1'b0 ||
                    out_funct3 !== 3'b101) begin failures++;
         $display("FAIL lhu_ok got=%h/%b/%0h/%0d exp=3002/1100/0/5", out_addr, out_mask,
                  out_misaligned, out_funct3); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_flush_reset();
      for (int k = 0; k < 4; k++) begin
         drive_op(1'b0, 3'b010, 32'h0, 5'(20 + k), 6'd1, 1'b1, 32'h80, 6'd0, 1'b1, 32'h0);
         step();
      end
      idle();
      checks++; if (out_valid !== 1'b1 || out_rob_idx !== 5'd20) begin failures++;
         $display("FAIL flush_pre got=%0h/%0d exp=1/20", out_valid, out_rob_idx); end
      flush = 1'b1;
      drive_op(1'b0, 3'b010, 32'h0, 5'd24, 6'd1, 1'b1, 32'h80, 6'd0, 1'b1, 32'h0);
      step();
      idle();
      checks++; if (out_valid !== 1'b0 || disp_ready !== 1'b1) begin failures++;
         $display("FAIL flush_empty got=%0h/%0h exp=0/1", out_valid, disp_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++;
         $display("FAIL flush_no_disp got=%0h exp=0", out_valid); end
      for (int k = 0; k < 3; k++) begin
         drive_op(1'b0, 3'b010, 32'h0, 5'(25 + k), 6'd1, 1'b1, 32'h90, 6'd0, 1'b1, 32'h0);
         step();
      end
      idle();
      checks++; if (out_valid !== 1'b1) begin failures++;
         $display("FAIL midfill_pre got=%0h exp=1", out_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || disp_ready !== 1'b1 || out_addr !== 32'h0) begin
         failures++;
         $display("FAIL async_reset got=%0h/%0h/%h exp=0/1/0", out_valid, disp_ready,
                  out_addr); end
      step();
      rst = 1'b0;
      drive_op(1'b0, 3'b010, 32'h4, 5'd3, 6'd1, 1'b1, 32'h40, 6'd0, 1'b1, 32'h0);
      step();
      idle();
      checks++; if (out_valid !== 1'b1 || out_addr !== 32'h44 || out_rob_idx !== 5'd3) begin
         failures++;
         $display("FAIL post_reset got=%0h/%h/%0d exp=1/44/3", out_valid, out_addr,
                  out_rob_idx); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sb_wakeup();
      test_bypass();
      test_full_wrap();
      test_head_block();
      test_misaligned();
      test_flush_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
